demm_dot_engine: RTL and testbench
==================================

Name: demm_dot_engine

Overview:
Parametrised multi-lane signed integer dot-product engine; successor to the single-lane demm dot kernel.
- Consumes LANES element pairs per beat from two AXI-Stream-style inputs (A, B).
- Multiplies lanewise, reduces through a registered adder tree and accumulates over a per-job vector length.
- Emits one saturated result per job with a sticky overflow flag.
- Sits in the 250 MHz box between the operand fetch stage and the result writer.

Parameters:
LANES, 4, element pairs per beat (power of 2, >=1)
DATA_W, 16, signed element width
ACC_W, 48, signed accumulator/result width (>= 2*DATA_W+clog2(LANES))
LEN_W, 32, job length counter width (beats)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous reset, active-high
cfg_len  in  LEN_W  job length in beats
cfg_valid  in  1  job descriptor valid
cfg_ready  out  1  engine can accept a job
s_a_tdata  in  LANES*DATA_W  A elements, lane i at bits [i*DATA_W +: DATA_W]
s_a_tvalid  in  1  A beat valid
s_a_tready  out  1  A beat accepted
s_b_tdata  in  LANES*DATA_W  B elements, same packing
s_b_tvalid  in  1  B beat valid
s_b_tready  out  1  B beat accepted
m_tdata  out  ACC_W  dot-product result, signed
m_tuser  out  1  saturation occurred during this job
m_tvalid  out  1  result valid
m_tready  in  1  result accepted
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, beat counter, pipeline valids, accumulator and sat flag cleared.
  - Output reset values: cfg_ready=1, s_a_tready=0, s_b_tready=0, m_tvalid=0, m_tdata=0, m_tuser=0, busy=0.
  - Reset mid-job: job discarded, no result emitted, in-flight beats dropped.
- FSM states: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid: latch cfg_len, clear accumulator and sat flag.
  - cfg_len=0: go to OUT, m_tdata=0, m_tuser=0, m_tvalid asserted next cycle.
  - cfg_len>0: go to RUN.
- RUN:
  - Joint handshake: s_a_tready = s_b_tready = s_a_tvalid & s_b_tvalid & (count < len). A lone valid on either side is never accepted.
  - Each fire increments count.
  - When count reaches len, go to DRAIN. Further beats are held off (ready=0).
- Pipeline (no backpressure; results are only drained after the last beat):
  - S1: per-lane signed product, 2*DATA_W bits, registered.
  - S2: adder tree sum, 2*DATA_W+clog2(LANES) bits, sign-extended, registered.
  - S3: acc <= sat(acc + sum) at ACC_W+1 bits. On overflow, clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set the sticky sat flag.
  - Saturation is not cleared by subsequent in-range beats. Accumulation continues from the clamped value.
- DRAIN:
  - Wait until S1/S2/S3 valids are all 0.
  - Then go to OUT and assert m_tvalid in the same transition; m_tdata = acc, m_tuser = sat flag.
  - Latency: last input fire at cycle t gives m_tvalid=1 at cycle t+4.
- OUT:
  - m_tdata/m_tuser stable while m_tvalid=1 and m_tready=0.
  - On m_tvalid & m_tready: go to IDLE, m_tvalid=0 next cycle.
  - cfg_ready=0 in all states except IDLE, so back-to-back jobs need 1 idle cycle between result accept and the next cfg accept.
- Boundary conditions:
  - count compare is unsigned; cfg_len = 2^LEN_W-1 must run to completion without wrap.
  - cfg_valid outside IDLE is ignored (not consumed).

Test Plan:
- LANES=4, cfg_len=4, all A=1, B=1, both valid continuously -> m_tdata=16, m_tuser=0, m_tvalid 4 cycles after 4th fire.
- cfg_len=3, A lanes {1,-2,3,-4}, B lanes {5,6,-7,8} every beat (lane dot per beat -60) -> m_tdata=-180, m_tuser=0.
- cfg_len=0 -> m_tvalid=1 one cycle after cfg accept, m_tdata=0, no input beats consumed.
- ACC_W=36 instance, cfg_len=8, all elements -32768 (per-beat sum 2^32) -> m_tdata=34359738367 (2^35-1), m_tuser=1.
- A valid alone for 5 cycles, then B valid; result held with m_tready=0 for 6 cycles; cfg_valid pulsed during OUT:
  - no fire until both valid;
  - m_tdata stable during the hold;
  - cfg not accepted during OUT, accepted in IDLE after the handshake.
- rst=1 for 1 cycle after 2 of 4 beats of a job -> no result; next job cfg_len=1, A=B=2 per lane -> m_tdata=16.

Source files
------------

// File: rtl/demm_dot_engine.sv
// demm_dot_engine: multi-lane signed dot-product engine.
// Consumes LANES element pairs per beat, multiplies lanewise, reduces through a
// registered adder stage and accumulates with saturation over a per-job length.
module demm_dot_engine #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48,
    parameter int unsigned LEN_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [LANES*DATA_W-1:0] s_a_tdata,
    input  logic                    s_a_tvalid,
    output logic                    s_a_tready,
    input  logic [LANES*DATA_W-1:0] s_b_tdata,
    input  logic                    s_b_tvalid,
    output logic                    s_b_tready,
    output logic [ACC_W-1:0]        m_tdata,
    output logic                    m_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    busy
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned TREE_W = $clog2(LANES);
    localparam int unsigned SUM_W  = PROD_W + TREE_W;
    localparam int unsigned EXT_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;

    logic fire;
    logic cfg_take;

    logic signed [PROD_W-1:0] prod_c [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     v1_q;

    logic signed [SUM_W-1:0]  sum_c;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     v2_q;

    logic signed [EXT_W-1:0]  acc_ext_c;
    logic signed [ACC_W-1:0]  acc_c;
    logic                     acc_ovf_c;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     sat_q;

    // Both operand streams advance together; a lone valid never fires.
    assign s_a_tready = fire;
    assign s_b_tready = fire;

    // Next-state and handshake decode.
    always_comb begin
        state_next = state;
        cfg_take   = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_take   = 1'b1;
                    state_next = (cfg_len == '0) ? OUT : RUN;
                end
            end
            RUN: begin
                fire = s_a_tvalid & s_b_tvalid & (count_q < len_q);
                if (fire && ((count_q + LEN_W'(1)) == len_q)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!v1_q && !v2_q) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (m_tready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Job length latch and accepted-beat counter; count never exceeds len so it cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            count_q <= '0;
        end else if (cfg_take) begin
            len_q   <= cfg_len;
            count_q <= '0;
        end else if (fire) begin
            count_q <= count_q + LEN_W'(1);
        end
    end

    // Lanewise signed products.
    always_comb begin
        for (int i = 0; i < int'(LANES); i++) begin
            prod_c[i] = PROD_W'($signed(s_a_tdata[i*DATA_W +: DATA_W]))
                      * PROD_W'($signed(s_b_tdata[i*DATA_W +: DATA_W]));
        end
    end

    // Sign-extended reduction of the registered products.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum_c = sum_c + SUM_W'(prod_q[i]);
        end
    end

    // Saturating add of the beat sum into the accumulator, one guard bit wide.
    always_comb begin
        acc_ext_c = EXT_W'(acc_q) + EXT_W'(sum_q);
        acc_ovf_c = acc_ext_c[EXT_W-1] != acc_ext_c[EXT_W-2];
        if (acc_ovf_c) begin
            acc_c = acc_ext_c[EXT_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_c = acc_ext_c[ACC_W-1:0];
        end
    end

    // S1/S2 pipeline registers; no backpressure, valids simply shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            sum_q <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            v1_q <= fire;
            v2_q <= v1_q;
            if (fire) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    prod_q[i] <= prod_c[i];
                end
            end
            if (v1_q) begin
                sum_q <= sum_c;
            end
        end
    end

    // S3 accumulator with sticky saturation flag, cleared per job.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (cfg_take) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else if (v2_q) begin
            acc_q <= acc_c;
            sat_q <= sat_q | acc_ovf_c;
        end
    end

    // Registered status and result outputs, loaded on the transition into OUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tuser   <= 1'b0;
        end else begin
            cfg_ready <= (state_next == IDLE);
            busy      <= (state_next != IDLE);
            m_tvalid  <= (state_next == OUT);
            if (state == IDLE && state_next == OUT) begin
                m_tdata <= '0;
                m_tuser <= 1'b0;
            end else if (state == DRAIN && state_next == OUT) begin
                m_tdata <= acc_q;
                m_tuser <= sat_q;
            end
        end
    end

endmodule

// File: tb/tb_demm_dot_engine.sv
// Testbench for demm_dot_engine: directed table, hand-written corner sequences
// and randomized jobs checked against a saturating dot-product model.
// Two instances (ACC_W=48 and ACC_W=36) share all inputs.
module tb_demm_dot_engine;

    localparam int unsigned LANES   = 4;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned LEN_W   = 32;
    localparam int unsigned BW      = LANES * DATA_W;
    localparam int          TIMEOUT = 400;

    logic              clk = 1'b0;
    logic              rst;
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_valid;
    logic [BW-1:0]     s_a_tdata;
    logic              s_a_tvalid;
    logic [BW-1:0]     s_b_tdata;
    logic              s_b_tvalid;
    logic              m_tready;

    logic              cfg_ready, s_a_tready, s_b_tready, m_tuser, m_tvalid, busy;
    logic [47:0]       m_tdata;
    logic              cfg36_ready, a36_tready, b36_tready, m36_tuser, m36_tvalid, busy36;
    logic [35:0]       m36_tdata;

    always #5 clk = ~clk;

    demm_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(48), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready),
        .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .busy(busy)
    );

    demm_dot_engine #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(36), .LEN_W(LEN_W)) u_dut36 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_valid(cfg_valid), .cfg_ready(cfg36_ready),
        .s_a_tdata(s_a_tdata), .s_a_tvalid(s_a_tvalid), .s_a_tready(a36_tready),
        .s_b_tdata(s_b_tdata), .s_b_tvalid(s_b_tvalid), .s_b_tready(b36_tready),
        .m_tdata(m36_tdata), .m_tuser(m36_tuser), .m_tvalid(m36_tvalid), .m_tready(m_tready),
        .busy(busy36)
    );

    typedef struct {
        int unsigned   len;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        longint        exp48;
        bit            sat48;
        longint        exp36;
        bit            sat36;
        int            lat;
    } vec_t;

    typedef struct packed {
        longint d48;
        bit     u48;
        longint d36;
        bit     u36;
        int     fires;
        int     lat;
        bit     timeout;
        int     hs_bad;
        bit     drop_ok;
    } res_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [BW-1:0] a_q[$];
    logic [BW-1:0] b_q[$];

    vec_t vecs[6];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint dot(input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint s;
        s = 0;
        for (int i = 0; i < int'(LANES); i++) begin
            s += longint'($signed(a[i*DATA_W +: DATA_W])) * longint'($signed(b[i*DATA_W +: DATA_W]));
        end
        return s;
    endfunction

    // Reference: saturating running sum of the first len beat dot products.
    task automatic model(input int unsigned len, input int accw, output longint v, output bit s);
        longint mx, mn, t;
        mx = (longint'(1) <<< (accw - 1)) - 1;
        mn = -mx - 1;
        v = 0;
        s = 1'b0;
        for (int k = 0; k < int'(len); k++) begin
            t = v + dot(a_q[k], b_q[k]);
            if (t > mx) begin
                v = mx; s = 1'b1;
            end else if (t < mn) begin
                v = mn; s = 1'b1;
            end else begin
                v = t;
            end
        end
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            case ($urandom_range(0, 5))
                0:       v[i*DATA_W +: DATA_W] = 16'h8000;
                1:       v[i*DATA_W +: DATA_W] = 16'h7FFF;
                default: v[i*DATA_W +: DATA_W] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    task automatic fill_const(input int unsigned len, input logic [BW-1:0] a, input logic [BW-1:0] b);
        a_q.delete();
        b_q.delete();
        for (int i = 0; i < int'(len) + 2; i++) begin
            a_q.push_back(a);
            b_q.push_back(b);
        end
    endtask

    // Runs one job from cfg accept to result accept, presenting a_q/b_q beats.
    task automatic run_job(input int unsigned len, input bit rnd, output res_t r);
        int cyc, k, accept_cyc, last_fire_cyc;
        bit cfg_done, done, got;
        r = '0;
        cyc = 0; k = 0; accept_cyc = 0; last_fire_cyc = 0;
        cfg_done = 1'b0; done = 1'b0; got = 1'b0;
        while (!done && cyc < TIMEOUT) begin
            @(negedge clk);
            cfg_valid  = !cfg_done;
            cfg_len    = LEN_W'(len);
            s_a_tvalid = cfg_done && (k < a_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
            s_b_tvalid = cfg_done && (k < b_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
            s_a_tdata  = (k < a_q.size()) ? a_q[k] : '0;
            s_b_tdata  = (k < b_q.size()) ? b_q[k] : '0;
            m_tready   = !rnd || ($urandom_range(0, 2) != 0);
            #1;
            if (s_a_tready != s_b_tready) r.hs_bad++;
            if (s_a_tready && !(s_a_tvalid && s_b_tvalid)) r.hs_bad++;
            if (a36_tready != s_a_tready || b36_tready != s_b_tready) r.hs_bad++;
            if (cfg36_ready != cfg_ready || m36_tvalid != m_tvalid || busy36 != busy) r.hs_bad++;
            if (got && !m_tvalid) r.hs_bad++;
            if (got && m_tvalid && (longint'($signed(m_tdata)) != r.d48 || m_tuser != r.u48)) r.hs_bad++;
            if (!cfg_done) begin
                if (cfg_ready) begin
                    cfg_done   = 1'b1;
                    accept_cyc = cyc;
                end
            end else if (cfg_ready) begin
                r.hs_bad++;
            end
            if (s_a_tready) begin
                k++;
                last_fire_cyc = cyc;
            end
            if (m_tvalid && !got) begin
                got   = 1'b1;
                r.d48 = longint'($signed(m_tdata));
                r.u48 = m_tuser;
                r.d36 = longint'($signed(m36_tdata));
                r.u36 = m36_tuser;
                r.lat = cyc - ((len == 0) ? accept_cyc : last_fire_cyc);
            end
            if (m_tvalid && m_tready) done = 1'b1;
            cyc++;
        end
        @(negedge clk);
        cfg_valid  = 1'b0;
        s_a_tvalid = 1'b0;
        s_b_tvalid = 1'b0;
        m_tready   = 1'b0;
        #1;
        r.drop_ok = !m_tvalid && cfg_ready;
        r.fires   = k;
        r.timeout = !done;
    endtask

    task automatic check_job(input string tag, input res_t r, input int unsigned len,
                             input longint e48, input bit s48, input longint e36, input bit s36,
                             input int lat);
        chk({tag, "_timeout"}, longint'(r.timeout), 0);
        chk({tag, "_d48"}, r.d48, e48);
        chk({tag, "_u48"}, longint'(r.u48), longint'(s48));
        chk({tag, "_d36"}, r.d36, e36);
        chk({tag, "_u36"}, longint'(r.u36), longint'(s36));
        chk({tag, "_fires"}, longint'(r.fires), longint'(len));
        chk({tag, "_handshake"}, longint'(r.hs_bad), 0);
        chk({tag, "_release"}, longint'(r.drop_ok), 1);
        if (lat >= 0) chk({tag, "_latency"}, longint'(r.lat), longint'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t   r;
        longint e48, e36;
        bit     s48, s36;
        int     lone_bad, hold_bad, fires, w, seen;
        logic [47:0] hold_data;
        int unsigned len;

        vecs[0] = '{4, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 16, 0, 16, 0, 4};
        vecs[1] = '{3, 64'hFFFC_0003_FFFE_0001, 64'h0008_FFF9_0006_0005, -180, 0, -180, 0, 4};
        vecs[2] = '{0, 64'h0005_0005_0005_0005, 64'h0007_0007_0007_0007, 0, 0, 0, 0, 1};
        vecs[3] = '{8, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000,
                    64'sd34359738368, 0, 64'sd34359738367, 1, 4};
        vecs[4] = '{1, 64'h0002_0002_0002_0002, 64'h0002_0002_0002_0002, 16, 0, 16, 0, 4};
        vecs[5] = '{2, 64'h7FFF_7FFF_7FFF_7FFF, 64'h8000_8000_8000_8000,
                    -64'sd8589672448, 0, -64'sd8589672448, 0, 4};

        // Reset state, with operand valids asserted to show they are not accepted.
        rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0; m_tready = 1'b0;
        s_a_tdata = '1; s_b_tdata = '1; s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cfg_ready", longint'(cfg_ready), 1);
        chk("rst_a_ready", longint'(s_a_tready), 0);
        chk("rst_b_ready", longint'(s_b_tready), 0);
        chk("rst_m_tvalid", longint'(m_tvalid), 0);
        chk("rst_m_tdata", longint'(m_tdata), 0);
        chk("rst_m_tuser", longint'(m_tuser), 0);
        chk("rst_busy", longint'(busy), 0);
        @(negedge clk);
        rst = 1'b0; s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            fill_const(vecs[i].len, vecs[i].a, vecs[i].b);
            run_job(vecs[i].len, 1'b0, r);
            check_job($sformatf("vec%0d", i), r, vecs[i].len, vecs[i].exp48, vecs[i].sat48,
                      vecs[i].exp36, vecs[i].sat36, vecs[i].lat);
        end

        // Lone A valid, held result, cfg pulsed during OUT.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_len = 32'd2;
        #1;
        chk("seqA_cfg_ready", longint'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        s_a_tdata = 64'h0004_0003_0002_0001; s_b_tdata = 64'h0001_0001_0001_0001;
        s_a_tvalid = 1'b1; s_b_tvalid = 1'b0;
        lone_bad = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (s_a_tready || s_b_tready || a36_tready) lone_bad++;
            @(negedge clk);
        end
        chk("seqA_lone_valid", longint'(lone_bad), 0);
        s_b_tvalid = 1'b1;
        fires = 0; w = 0;
        while (fires < 2 && w < 20) begin
            #1;
            if (s_a_tready) fires++;
            w++;
            @(negedge clk);
            if (fires == 2) begin
                s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
            end
        end
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        chk("seqA_fires", longint'(fires), 2);
        m_tready = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (m_tvalid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("seqA_result_seen", longint'(seen), 1);
        hold_data = m_tdata;
        chk("seqA_data", longint'($signed(m_tdata)), 20);
        hold_bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cfg_valid = 1'b1; cfg_len = 32'd1;
            #1;
            if (!m_tvalid || m_tdata != hold_data || m_tuser || cfg_ready || !busy) hold_bad++;
        end
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        if (cfg_ready || !m_tvalid) hold_bad++;
        chk("seqA_hold", longint'(hold_bad), 0);
        @(negedge clk);
        m_tready = 1'b0; cfg_valid = 1'b0;
        #1;
        chk("seqA_tvalid_drop", longint'(m_tvalid), 0);
        chk("seqA_idle_ready", longint'(cfg_ready), 1);
        fill_const(1, 64'h0004_0003_0002_0001, 64'h0001_0001_0001_0001);
        run_job(1, 1'b0, r);
        check_job("seqA_next", r, 1, 10, 0, 10, 0, 4);

        // Reset after 2 of 4 beats: job discarded.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_len = 32'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        s_a_tdata = 64'h0003_0003_0003_0003; s_b_tdata = 64'h0003_0003_0003_0003;
        s_a_tvalid = 1'b1; s_b_tvalid = 1'b1;
        fires = 0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (s_a_tready) fires++;
            @(negedge clk);
        end
        chk("seqB_fires", longint'(fires), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("seqB_cfg_ready", longint'(cfg_ready), 1);
        chk("seqB_busy", longint'(busy), 0);
        chk("seqB_a_ready", longint'(s_a_tready), 0);
        chk("seqB_m_tdata", longint'(m_tdata), 0);
        s_a_tvalid = 1'b0; s_b_tvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (m_tvalid || m36_tvalid) seen = 1;
        end
        chk("seqB_no_result", longint'(seen), 0);
        fill_const(1, 64'h0002_0002_0002_0002, 64'h0002_0002_0002_0002);
        run_job(1, 1'b0, r);
        check_job("seqB_next", r, 1, 16, 0, 16, 0, 4);

        // Randomized jobs against the model.
        for (int j = 0; j < 40; j++) begin
            a_q.delete();
            b_q.delete();
            if (j % 5 == 4) begin
                len = $urandom_range(9, 12);
                for (int k = 0; k < int'(len) + 2; k++) begin
                    a_q.push_back((j % 10 == 4) ? 64'h8000_8000_8000_8000 : 64'h7FFF_7FFF_7FFF_7FFF);
                    b_q.push_back(64'h8000_8000_8000_8000);
                end
            end else begin
                len = $urandom_range(0, 10);
                for (int k = 0; k < int'(len) + 2; k++) begin
                    a_q.push_back(rand_beat());
                    b_q.push_back(rand_beat());
                end
            end
            model(len, 48, e48, s48);
            model(len, 36, e36, s36);
            run_job(len, 1'b1, r);
            check_job($sformatf("rnd%0d", j), r, len, e48, s48, e36, s36, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
